bus_sram_target: RTL and testbench



---
 rtl/bus_sram_target_if.sv | 29 ++
 rtl/bus_sram_target.sv | 173 +++++++++++++++++
 tb/tb_bus_sram_target.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_sram_target_if.sv
// Shared-bus signal bundle between the DMA master and the scratchpad SRAM target.
// The *IN signals are driven by the master and the *OUT signals by the target.
interface bus_sram_target_if;
  logic [31:0] address_dataIN;
  logic [3:0]  byte_enableIN;
  logic [7:0]  burst_sizeIN;
  logic        read_n_writeIN;
  logic        begin_transactionIN;
  logic        end_transactionIN;
  logic        data_validIN;
  logic        busyIN;
  logic [31:0] address_dataOUT;
  logic        data_validOUT;
  logic        end_transactionOUT;
  logic        busyOUT;
  logic        errorOUT;

  modport master (
    output address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
           begin_transactionIN, end_transactionIN, data_validIN, busyIN,
    input  address_dataOUT, data_validOUT, end_transactionOUT, busyOUT, errorOUT
  );

  modport slave (
    input  address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
           begin_transactionIN, end_transactionIN, data_validIN, busyIN,
    output address_dataOUT, data_validOUT, end_transactionOUT, busyOUT, errorOUT
  );
endinterface

// File: rtl/bus_sram_target.sv
// Burst-capable scratchpad SRAM target on the shared system bus.
// Optional feature: define BUS_SRAM_RANGE_CHECK_EN to reject bursts running past the last word.
module bus_sram_target #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0400_0000,
  parameter int unsigned ADDRESS_BITS = 10
) (
  input  logic             clock,
  input  logic             reset,
  bus_sram_target_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDRESS_BITS;
  localparam logic [ADDRESS_BITS-1:0] PTR_ONE = ADDRESS_BITS'(1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE      = 3'd1,
    READ_FETCH = 3'd2,
    READ       = 3'd3,
    READ_END   = 3'd4,
    ERROR      = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] ptr_q, ptr_d;
  logic [ADDRESS_BITS-1:0] rd_addr_s;
  logic [ADDRESS_BITS-1:0] start_word_s;
  logic [7:0]              cnt_q, cnt_d;
  logic [3:0]              be_q, be_d;
  logic                    done_q, done_d;
  logic                    valid_q, valid_d;
  logic                    end_q, end_d;
  logic                    err_q, err_d;
  logic                    wr_en_s, rd_en_s, hit_s, range_err_s;
  logic [31:0]             rdata_q;
  logic [31:0]             mem_q [DEPTH];

  assign hit_s        = (bus.address_dataIN[31:ADDRESS_BITS+2] == BASE_ADDRESS[31:ADDRESS_BITS+2]);
  assign start_word_s = bus.address_dataIN[ADDRESS_BITS+1:2];

`ifdef BUS_SRAM_RANGE_CHECK_EN
  logic [31:0] span_end_s;
  assign span_end_s  = 32'(start_word_s) + 32'(bus.burst_sizeIN);
  assign range_err_s = (span_end_s > 32'(DEPTH - 1));
`else
  assign range_err_s = 1'b0;
`endif

  // Next-state and next-output decode for the transaction FSM.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    be_d      = be_q;
    done_d    = done_q;
    valid_d   = 1'b0;
    end_d     = 1'b0;
    err_d     = 1'b0;
    wr_en_s   = 1'b0;
    rd_en_s   = 1'b0;
    rd_addr_s = ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.begin_transactionIN && hit_s) begin
          ptr_d  = start_word_s;
          cnt_d  = bus.burst_sizeIN;
          be_d   = bus.byte_enableIN;
          done_d = 1'b0;
          if (range_err_s) begin
            state_d = ERROR;
            err_d   = 1'b1;
            end_d   = 1'b1;
          end else if (bus.read_n_writeIN) begin
            state_d = READ_FETCH;
          end else begin
            state_d = WRITE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (bus.end_transactionIN) begin
          state_d = IDLE;
        end else if (bus.data_validIN && !done_q) begin
          wr_en_s = 1'b1;
          ptr_d   = ptr_q + PTR_ONE;
          if (cnt_q == 8'd0) begin
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end else begin
          state_d = WRITE;
        end
      end
      READ_FETCH: begin
        if (bus.end_transactionIN) begin
          state_d = IDLE;
        end else begin
          rd_en_s = 1'b1;
          valid_d = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        if (bus.end_transactionIN) begin
          state_d = IDLE;
        end else if (valid_q && !bus.busyIN) begin
          if (cnt_q == 8'd0) begin
            end_d   = 1'b1;
            state_d = READ_END;
          end else begin
            // Fetch the next word on the accepting edge so valid never drops mid-burst.
            ptr_d     = ptr_q + PTR_ONE;
            cnt_d     = cnt_q - 8'd1;
            rd_en_s   = 1'b1;
            rd_addr_s = ptr_q + PTR_ONE;
            valid_d   = 1'b1;
          end
        end else begin
          valid_d = 1'b1;
        end
      end
      READ_END: state_d = IDLE;
      ERROR:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Control state and registered bus outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= 8'd0;
      be_q    <= 4'd0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      be_q    <= be_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      end_q   <= end_d;
      err_q   <= err_d;
    end
  end

  // Storage array: byte-masked write port and synchronous read port, contents never reset.
  always_ff @(posedge clock) begin
    if (wr_en_s && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem_q[ptr_q][8*b +: 8] <= bus.address_dataIN[8*b +: 8];
        end
      end
    end
    if (rd_en_s) begin
      rdata_q <= mem_q[rd_addr_s];
    end
  end

  // Zero when idle so the bus can OR-combine agents.
  assign bus.address_dataOUT    = valid_q ? rdata_q : 32'h0;
  assign bus.data_validOUT      = valid_q;
  assign bus.end_transactionOUT = end_q;
  assign bus.busyOUT            = 1'b0;
  assign bus.errorOUT           = err_q;
endmodule

// File: tb/tb_bus_sram_target.sv
// Scoreboard bench for bus_sram_target: read words expected from a bench-side memory
// model are queued when a read is issued and compared as the DUT delivers beats.
module tb_bus_sram_target;
  localparam int AB    = 10;
  localparam int DEPTH = 1 << AB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_sram_target_if bus();

  bus_sram_target #(
    .BASE_ADDRESS (32'h0400_0000),
    .ADDRESS_BITS (AB)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_q [$];
  logic [31:0] exp_word;
  int n_checks = 0;
  int n_pass   = 0;
  int n_beats  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_ctl"}, {28'h0, bus.data_validOUT, bus.end_transactionOUT, bus.busyOUT, bus.errorOUT}, 32'h0);
    check_eq({tag, "_data"}, bus.address_dataOUT, 32'h0);
  endtask

  // Scoreboard side: every accepted read beat is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.data_validOUT && !bus.busyIN) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          check_eq("beat_without_expectation", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_word = exp_q.pop_front();
          check_eq("read_data", bus.address_dataOUT, exp_word);
        end
      end else if (!bus.data_validOUT) begin
        check_eq("data_zero_when_invalid", bus.address_dataOUT, 32'h0);
      end
    end
  end

  task automatic write_burst(input logic [31:0] addr, input logic [3:0] be, input logic [7:0] bsize,
                             input int nbeats, input logic [31:0] base, input logic [31:0] step);
    logic [AB-1:0] w;
    logic [31:0]   d;
    w = addr[AB+1:2];
    bus.address_dataIN      = addr;
    bus.byte_enableIN       = be;
    bus.burst_sizeIN        = bsize;
    bus.read_n_writeIN      = 1'b0;
    bus.begin_transactionIN = 1'b1;
    tick();
    bus.begin_transactionIN = 1'b0;
    bus.byte_enableIN       = 4'h0;
    bus.burst_sizeIN        = 8'd0;
    for (int i = 0; i < nbeats; i++) begin
      d = base + step * 32'(i);
      bus.address_dataIN = d;
      bus.data_validIN   = 1'b1;
      if (i <= int'(bsize)) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model_mem[w][8*b +: 8] = d[8*b +: 8];
        end
        w = w + AB'(1);
      end
      tick();
    end
    bus.data_validIN      = 1'b0;
    bus.address_dataIN    = 32'h0;
    bus.end_transactionIN = 1'b1;
    tick();
    bus.end_transactionIN = 1'b0;
  endtask

  task automatic read_burst(input string tag, input logic [31:0] addr, input int n, input bit busy_first);
    logic [AB-1:0] w;
    int beats0;
    int waited;
    w = addr[AB+1:2];
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_mem[w]);
      w = w + AB'(1);
    end
    beats0 = n_beats;
    bus.address_dataIN      = addr;
    bus.burst_sizeIN        = 8'(n - 1);
    bus.read_n_writeIN      = 1'b1;
    bus.begin_transactionIN = 1'b1;
    tick();
    bus.begin_transactionIN = 1'b0;
    bus.address_dataIN      = 32'h0;
    bus.burst_sizeIN        = 8'd0;
    tick();
    check_eq({tag, "_first_valid"}, 32'(bus.data_validOUT), 32'd1);
    waited = 1;
    if (busy_first) begin
      bus.busyIN = 1'b1;
      tick();
      waited++;
      check_eq({tag, "_hold_valid"}, 32'(bus.data_validOUT), 32'd1);
      check_eq({tag, "_hold_data"}, bus.address_dataOUT, exp_q[0]);
      bus.busyIN = 1'b0;
    end
    while (!bus.end_transactionOUT && waited < 64) begin
      tick();
      waited++;
    end
    check_eq({tag, "_end_cycle"}, 32'(waited), 32'(n + 1 + (busy_first ? 1 : 0)));
    check_eq({tag, "_beats"}, 32'(n_beats - beats0), 32'(n));
    tick();
    check_quiet({tag, "_after_end"});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.address_dataIN      = 32'h0;
    bus.byte_enableIN       = 4'h0;
    bus.burst_sizeIN        = 8'd0;
    bus.read_n_writeIN      = 1'b0;
    bus.begin_transactionIN = 1'b0;
    bus.end_transactionIN   = 1'b0;
    bus.data_validIN        = 1'b0;
    bus.busyIN              = 1'b0;
    rst = 1'b1;
    tick(); tick(); tick();
    check_quiet("reset");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_quiet("idle");
    end

    // Four-beat burst at words 4..7 and read-back.
    write_burst(32'h0400_0010, 4'hF, 8'd3, 4, 32'h1111_1111, 32'h1111_1111);
    read_burst("burst4", 32'h0400_0010, 4, 1'b0);

    // Byte-lane masking over a zeroed word.
    write_burst(32'h0400_0020, 4'hF, 8'd0, 1, 32'h0, 32'h0);
    write_burst(32'h0400_0020, 4'b0101, 8'd0, 1, 32'hAABB_CCDD, 32'h0);
    read_burst("bytemask", 32'h0400_0020, 1, 1'b0);

    // Master stall on the first beat.
    read_burst("busy", 32'h0400_0014, 2, 1'b1);

    // Begin outside the address window.
    bus.address_dataIN      = 32'h0800_0000;
    bus.burst_sizeIN        = 8'd3;
    bus.read_n_writeIN      = 1'b1;
    bus.begin_transactionIN = 1'b1;
    tick();
    bus.begin_transactionIN = 1'b0;
    bus.address_dataIN      = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_quiet("out_of_window");
    end

    // Abort mid-read.
    bus.address_dataIN      = 32'h0400_0010;
    bus.burst_sizeIN        = 8'd7;
    bus.read_n_writeIN      = 1'b1;
    bus.begin_transactionIN = 1'b1;
    tick();
    bus.begin_transactionIN = 1'b0;
    bus.address_dataIN      = 32'h0;
    tick();
    check_eq("abort_valid_before", 32'(bus.data_validOUT), 32'd1);
    bus.busyIN            = 1'b1;
    bus.end_transactionIN = 1'b1;
    tick();
    bus.busyIN            = 1'b0;
    bus.end_transactionIN = 1'b0;
    check_quiet("abort_read");
    tick();
    check_quiet("abort_read_settled");

    // Write abort: a stray beat after end must not land.
    write_burst(32'h0400_0078, 4'hF, 8'd1, 2, 32'h3030_3030, 32'h0101_0101);
    write_burst(32'h0400_0078, 4'hF, 8'd3, 1, 32'h7777_0000, 32'h0);
    bus.address_dataIN = 32'h9999_9999;
    bus.data_validIN   = 1'b1;
    tick();
    bus.data_validIN   = 1'b0;
    bus.address_dataIN = 32'h0;
    read_burst("write_abort", 32'h0400_0078, 2, 1'b0);

    // Beats beyond the burst length are discarded.
    write_burst(32'h0400_0050, 4'hF, 8'd1, 2, 32'h0, 32'h0);
    write_burst(32'h0400_0050, 4'hF, 8'd0, 2, 32'hCAFE_0000, 32'h1111_0000);
    read_burst("discard", 32'h0400_0050, 2, 1'b0);

    // Last-word boundary.
    write_burst(32'h0400_0FFC, 4'hF, 8'd0, 1, 32'hDDDD_0FFC, 32'h0);
    write_burst(32'h0400_0000, 4'hF, 8'd0, 1, 32'hDDDD_0000, 32'h0);
`ifdef BUS_SRAM_RANGE_CHECK_EN
    bus.address_dataIN      = 32'h0400_0FFC;
    bus.byte_enableIN       = 4'hF;
    bus.burst_sizeIN        = 8'd1;
    bus.read_n_writeIN      = 1'b0;
    bus.begin_transactionIN = 1'b1;
    tick();
    bus.begin_transactionIN = 1'b0;
    check_eq("range_err_pulse", 32'(bus.errorOUT), 32'd1);
    check_eq("range_end_pulse", 32'(bus.end_transactionOUT), 32'd1);
    bus.address_dataIN = 32'h5A5A_0001;
    bus.data_validIN   = 1'b1;
    tick();
    check_eq("range_err_clear", {30'h0, bus.errorOUT, bus.end_transactionOUT}, 32'h0);
    bus.address_dataIN = 32'h5A5A_0002;
    tick();
    bus.data_validIN   = 1'b0;
    bus.address_dataIN = 32'h0;
    bus.burst_sizeIN   = 8'd0;
    tick();
    read_burst("range_last_kept", 32'h0400_0FFC, 1, 1'b0);
    read_burst("range_first_kept", 32'h0400_0000, 1, 1'b0);
`else
    write_burst(32'h0400_0FFC, 4'hF, 8'd1, 2, 32'h5A5A_0001, 32'h1);
    read_burst("wrap", 32'h0400_0FFC, 2, 1'b0);
    read_burst("wrap_word0", 32'h0400_0000, 1, 1'b0);
`endif

    // Reset mid-burst abandons the read.
    bus.address_dataIN      = 32'h0400_0010;
    bus.burst_sizeIN        = 8'd7;
    bus.read_n_writeIN      = 1'b1;
    bus.begin_transactionIN = 1'b1;
    tick();
    bus.begin_transactionIN = 1'b0;
    bus.address_dataIN      = 32'h0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_quiet("reset_mid_burst");
    tick();
    check_quiet("reset_mid_burst_settled");

    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
